// File: rtl/controlador_entrada_rpn_if.sv
// controlador_entrada_rpn_if: key events in, stack strobes and status out
interface controlador_entrada_rpn_if;
  logic       tecla_digito;
  logic [3:0] valor_digito;
  logic       tecla_enter;
  logic       tecla_op;
  logic [2:0] codigo_op;
  logic       tecla_limpar;
  logic [7:0] entrada;
  logic       entrada_numero;
  logic [2:0] operacao;
  logic       entrada_operacao;
  logic       executar;
  logic [7:0] valor_parcial;
  logic [1:0] num_digitos;
  logic [2:0] profundidade;
  logic       ocupado;
  logic       erro_entrada;
  logic       erro_pilha;
  modport master (
    output tecla_digito, valor_digito, tecla_enter, tecla_op, codigo_op, tecla_limpar,
    input  entrada, entrada_numero, operacao, entrada_operacao, executar,
           valor_parcial, num_digitos, profundidade, ocupado, erro_entrada, erro_pilha
  );
  modport slave (
    input  tecla_digito, valor_digito, tecla_enter, tecla_op, codigo_op, tecla_limpar,
    output entrada, entrada_numero, operacao, entrada_operacao, executar,
           valor_parcial, num_digitos, profundidade, ocupado, erro_entrada, erro_pilha
  );
endinterface

// File: rtl/controlador_entrada_rpn.sv
// controlador_entrada_rpn: turns key events into push/op/execute strobes for the RPN stack
module controlador_entrada_rpn #(
  parameter int MAX_DIGITOS  = 3,
  parameter int PROFUNDIDADE = 4
) (
  input logic clk,
  input logic rst,
  controlador_entrada_rpn_if.slave bus
);
  localparam logic [2:0] OCIOSO   = 3'd0;
  localparam logic [2:0] ACUM     = 3'd1;
  localparam logic [2:0] PUSH     = 3'd2;
  localparam logic [2:0] OP_LATCH = 3'd3;
  localparam logic [2:0] EXEC     = 3'd4;
  localparam logic [2:0] ERRO     = 3'd5;
  logic [2:0]  estado;
  logic [7:0]  acc;
  logic [7:0]  ent;
  logic [1:0]  ndig;
  logic [2:0]  prof;
  logic [2:0]  op_reg;
  logic [2:0]  op_sav;
  logic        op_pend;
  logic        clr_pend;
  logic        err_e;
  logic        err_p;
  logic [11:0] prox;
  logic        dig_ruim;
  logic        cheia;
  logic        fim_limpa;
  always_comb begin
    prox      = 12'(acc) * 12'd10 + 12'(bus.valor_digito);
    dig_ruim  = bus.valor_digito > 4'd9 || prox > 12'd255 || ndig == 2'(MAX_DIGITOS);
    cheia     = prof == 3'(PROFUNDIDADE);
    fim_limpa = clr_pend || bus.tecla_limpar;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado   <= OCIOSO;
      acc      <= 8'd0;
      ent      <= 8'd0;
      ndig     <= 2'd0;
      prof     <= 3'd0;
      op_reg   <= 3'd0;
      op_sav   <= 3'd0;
      op_pend  <= 1'b0;
      clr_pend <= 1'b0;
      err_e    <= 1'b0;
      err_p    <= 1'b0;
    end else begin
      ent <= 8'd0;
      case (estado)
        OCIOSO, ACUM:
          if (bus.tecla_limpar) begin
            acc    <= 8'd0;
            ndig   <= 2'd0;
            err_e  <= 1'b0;
            err_p  <= 1'b0;
            estado <= OCIOSO;
          end else if (bus.tecla_enter || (bus.tecla_op && estado == ACUM)) begin
            // enter with nothing typed is dropped; an op with a pending operand pushes it first
            if (estado == ACUM) begin
              acc     <= 8'd0;
              ndig    <= 2'd0;
              op_pend <= !bus.tecla_enter;
              op_sav  <= bus.codigo_op;
              if (cheia) begin
                err_p  <= 1'b1;
                estado <= OCIOSO;
              end else begin
                ent    <= acc;
                estado <= PUSH;
              end
            end
          end else if (bus.tecla_op) begin
            if (prof < 3'd2) err_p <= 1'b1;
            else begin
              op_reg <= bus.codigo_op;
              estado <= OP_LATCH;
            end
          end else if (bus.tecla_digito) begin
            if (dig_ruim) begin
              err_e  <= 1'b1;
              estado <= ERRO;
            end else begin
              acc    <= prox[7:0];
              ndig   <= ndig + 2'd1;
              estado <= ACUM;
            end
          end
        PUSH: begin
          prof <= prof + 3'd1;
          if (op_pend && prof != 3'd0) begin
            op_reg   <= op_sav;
            clr_pend <= fim_limpa;
            estado   <= OP_LATCH;
          end else begin
            err_p    <= !fim_limpa && (err_p || op_pend);
            clr_pend <= 1'b0;
            estado   <= OCIOSO;
          end
        end
        OP_LATCH: begin
          clr_pend <= fim_limpa;
          estado   <= EXEC;
        end
        EXEC: begin
          prof     <= prof - 3'd1;
          err_p    <= err_p && !fim_limpa;
          clr_pend <= 1'b0;
          estado   <= OCIOSO;
        end
        ERRO:
          if (bus.tecla_limpar) begin
            acc    <= 8'd0;
            ndig   <= 2'd0;
            err_e  <= 1'b0;
            err_p  <= 1'b0;
            estado <= OCIOSO;
          end
        default: estado <= OCIOSO;
      endcase
    end
  end
  assign bus.entrada          = ent;
  assign bus.entrada_numero   = estado == PUSH;
  assign bus.operacao         = op_reg;
  assign bus.entrada_operacao = estado == OP_LATCH;
  assign bus.executar         = estado == EXEC;
  assign bus.valor_parcial    = acc;
  assign bus.num_digitos      = ndig;
  assign bus.profundidade     = prof;
  assign bus.ocupado          = !(estado == OCIOSO || estado == ACUM);
  assign bus.erro_entrada     = err_e;
  assign bus.erro_pilha       = err_p;
endmodule
